// File: rtl/alu_op_sequencer_if.sv
// Request/response bus between the control unit (master) and the ALU
// operation sequencer (slave).
interface alu_op_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_lo;
  logic [WIDTH-1:0] rsp_hi;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts one op request, drives registered A/B/Op
// into a combinational ALU, holds them for a per-op settle time so MUL/DIV
// can be constrained as multicycle paths, then returns LO/HI.
// Optional feature: define DIV_ZERO_TRAP_EN to reject divide-by-zero
// requests (op 3 with B == 0) as errors instead of issuing them.
module alu_op_sequencer #(
  parameter int WIDTH       = 32,
  parameter int SIMPLE_WAIT = 1,
  parameter int MULDIV_WAIT = 4
) (
  input  logic                 clock,
  input  logic                 clear,
  alu_op_sequencer_if.slave    bus,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [3:0]           alu_op,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic [WIDTH-1:0]     alu_out2
);

  localparam int MAX_WAIT = (MULDIV_WAIT > SIMPLE_WAIT) ? MULDIV_WAIT : SIMPLE_WAIT;
  localparam int CW       = $clog2(MAX_WAIT) + 1;

  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MUL = 4'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   count;
  logic            accept;
  logic            op_valid;
  logic            reject;
  logic            req_muldiv;
  logic            cur_muldiv;
  logic            count_done;

  assign accept     = bus.req_valid && (state == IDLE);
  assign op_valid   = (bus.req_op >= 4'd1) && (bus.req_op <= 4'd11);
  assign req_muldiv = (bus.req_op == OP_DIV) || (bus.req_op == OP_MUL);
  assign cur_muldiv = (alu_op == OP_DIV) || (alu_op == OP_MUL);
  assign count_done = (count == '0);

`ifdef DIV_ZERO_TRAP_EN
  assign reject = !op_valid || ((bus.req_op == OP_DIV) && (bus.req_b == '0));
`else
  assign reject = !op_valid;
`endif

  // State register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = reject ? RESP : WAIT;
      WAIT: if (count_done) state_next = RESP;
      RESP: if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are pure functions of state
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
  end

  // Operand issue, settle counter and result capture
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      count       <= '0;
      bus.rsp_lo  <= '0;
      bus.rsp_hi  <= '0;
      bus.rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (reject) begin
              bus.rsp_lo  <= '0;
              bus.rsp_hi  <= '0;
              bus.rsp_err <= 1'b1;
            end else begin
              alu_a  <= bus.req_a;
              alu_b  <= bus.req_b;
              alu_op <= bus.req_op;
              count  <= req_muldiv ? CW'(MULDIV_WAIT - 1) : CW'(SIMPLE_WAIT - 1);
            end
          end
        end
        WAIT: begin
          if (count_done) begin
            // alu_op is still the issued op here, so it selects HI gating
            bus.rsp_lo  <= alu_out;
            bus.rsp_hi  <= cur_muldiv ? alu_out2 : '0;
            bus.rsp_err <= 1'b0;
            alu_op      <= '0;
          end else begin
            count <= count - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed, table-driven bench for alu_op_sequencer with a behavioural
// signed ALU attached to the issue ports.
module tb_alu_op_sequencer;

  logic        clock;
  logic        clear;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;
  logic [31:0] alu_out2;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  alu_op_sequencer_if #(.WIDTH(32)) bus ();

  alu_op_sequencer #(
    .WIDTH(32),
    .SIMPLE_WAIT(1),
    .MULDIV_WAIT(4)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus(bus),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .alu_out(alu_out),
    .alu_out2(alu_out2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU; junk on alu_out2 for non-mul/div ops and on both
  // outputs when idle, so uncaptured values are visible if used
  logic signed [63:0] prod;
  logic [4:0]         sh;
  always_comb begin
    prod     = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});
    sh       = alu_b[4:0];
    alu_out  = 32'hDEADBEEF;
    alu_out2 = 32'hA5A5A5A5;
    case (alu_op)
      4'd1: alu_out = alu_a + alu_b;
      4'd2: alu_out = alu_a - alu_b;
      4'd3: begin
        if (alu_b == 32'd0) begin
          alu_out  = 32'hFFFFFFFF;
          alu_out2 = alu_a;
        end else begin
          alu_out  = $signed(alu_a) / $signed(alu_b);
          alu_out2 = $signed(alu_a) % $signed(alu_b);
        end
      end
      4'd4: begin
        alu_out  = prod[31:0];
        alu_out2 = prod[63:32];
      end
      4'd5:  alu_out = alu_a & alu_b;
      4'd6:  alu_out = alu_a | alu_b;
      4'd7:  alu_out = alu_a >> sh;
      4'd8:  alu_out = $signed(alu_a) >>> sh;
      4'd9:  alu_out = alu_a << sh;
      4'd10: alu_out = (alu_a >> sh) | (alu_a << (6'd32 - {1'b0, sh}));
      4'd11: alu_out = (alu_a << sh) | (alu_a >> (6'd32 - {1'b0, sh}));
      default: ;
    endcase
  end

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
    int unsigned lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int unsigned lat;
    @(negedge clock);
    chk({v.name, " req_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = v.op;
    bus.req_a     = v.a;
    bus.req_b     = v.b;
    @(negedge clock);
    bus.req_valid = 1'b0;
    bus.req_op    = 4'd0;
    bus.req_a     = 32'h12345678;
    bus.req_b     = 32'h9ABCDEF0;
    if (v.err) chk({v.name, " alu_op idle"}, 64'(alu_op), 64'd0);
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      chk({v.name, " alu_op hold"}, 64'(alu_op), 64'(v.op));
      chk({v.name, " alu_a hold"}, 64'(alu_a), 64'(v.a));
      chk({v.name, " alu_b hold"}, 64'(alu_b), 64'(v.b));
      @(negedge clock);
      lat++;
    end
    chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
    chk({v.name, " lo"}, 64'(bus.rsp_lo), 64'(v.lo));
    chk({v.name, " hi"}, 64'(bus.rsp_hi), 64'(v.hi));
    chk({v.name, " err"}, 64'(bus.rsp_err), 64'(v.err));
    chk({v.name, " req_ready in resp"}, 64'(bus.req_ready), 64'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    chk({v.name, " rsp_valid drop"}, 64'(bus.rsp_valid), 64'd0);
    chk({v.name, " back to idle"}, 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back('{"add",    4'd1,  32'd5,          32'd7,          32'd12,         32'd0,          1'b0, 1});
    vecs.push_back('{"mul",    4'd4,  32'hFFFFFFFE,   32'd3,          32'hFFFFFFFA,   32'hFFFFFFFF,   1'b0, 4});
    vecs.push_back('{"div",    4'd3,  32'd17,         32'd5,          32'd3,          32'd2,          1'b0, 4});
    vecs.push_back('{"inv12",  4'd12, 32'd1,          32'd2,          32'd0,          32'd0,          1'b1, 0});
    vecs.push_back('{"sub",    4'd2,  32'd5,          32'd7,          32'hFFFFFFFE,   32'd0,          1'b0, 1});
    vecs.push_back('{"and",    4'd5,  32'hF0F000FF,   32'h0FF00F0F,   32'h00F0000F,   32'd0,          1'b0, 1});
    vecs.push_back('{"or",     4'd6,  32'hF0000000,   32'h0000000F,   32'hF000000F,   32'd0,          1'b0, 1});
    vecs.push_back('{"shr",    4'd7,  32'h80000000,   32'd4,          32'h08000000,   32'd0,          1'b0, 1});
    vecs.push_back('{"shra",   4'd8,  32'h80000000,   32'd4,          32'hF8000000,   32'd0,          1'b0, 1});
    vecs.push_back('{"shl",    4'd9,  32'd1,          32'd31,         32'h80000000,   32'd0,          1'b0, 1});
    vecs.push_back('{"ror",    4'd10, 32'd1,          32'd1,          32'h80000000,   32'd0,          1'b0, 1});
    vecs.push_back('{"rol",    4'd11, 32'h80000000,   32'd4,          32'h00000008,   32'd0,          1'b0, 1});
    vecs.push_back('{"divneg", 4'd3,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 4});
    vecs.push_back('{"inv0",   4'd0,  32'd3,          32'd3,          32'd0,          32'd0,          1'b1, 0});
    vecs.push_back('{"inv15",  4'd15, 32'd3,          32'd3,          32'd0,          32'd0,          1'b1, 0});
`ifdef DIV_ZERO_TRAP_EN
    vecs.push_back('{"div0",   4'd3,  32'd17,         32'd0,          32'd0,          32'd0,          1'b1, 0});
`else
    vecs.push_back('{"div0",   4'd3,  32'd17,         32'd0,          32'hFFFFFFFF,   32'd17,         1'b0, 4});
`endif

    bus.req_valid = 1'b0;
    bus.req_op    = 4'd0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    clear = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset req_ready", 64'(bus.req_ready), 64'd1);
    chk("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset alu_op", 64'(alu_op), 64'd0);
    chk("reset alu_a", 64'(alu_a), 64'd0);
    chk("reset alu_b", 64'(alu_b), 64'd0);
    chk("reset rsp_lo", 64'(bus.rsp_lo), 64'd0);
    chk("reset rsp_hi", 64'(bus.rsp_hi), 64'd0);
    chk("reset rsp_err", 64'(bus.rsp_err), 64'd0);
    clear = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Response back-pressure; a request held during RESP must not be taken
    // on the same edge that retires the response
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_op    = 4'd1;
    bus.req_a     = 32'd20;
    bus.req_b     = 32'd22;
    @(negedge clock);
    bus.req_a     = 32'd100;
    bus.req_b     = 32'd1;
    chk("bp alu_op issued", 64'(alu_op), 64'd1);
    @(negedge clock);
    chk("bp rsp_valid", 64'(bus.rsp_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp rsp_valid held", 64'(bus.rsp_valid), 64'd1);
      chk("bp rsp_lo held", 64'(bus.rsp_lo), 64'd42);
      chk("bp rsp_hi held", 64'(bus.rsp_hi), 64'd0);
      chk("bp req_ready low", 64'(bus.req_ready), 64'd0);
      chk("bp no issue", 64'(alu_op), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    chk("bp retire rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("bp retire req_ready", 64'(bus.req_ready), 64'd1);
    chk("bp not accepted same edge", 64'(alu_op), 64'd0);
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("bp second issue op", 64'(alu_op), 64'd1);
    chk("bp second issue a", 64'(alu_a), 64'd100);
    @(negedge clock);
    chk("bp second rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("bp second rsp_lo", 64'(bus.rsp_lo), 64'd101);
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;

    // Asynchronous clear in the middle of a multiply
    bus.req_valid = 1'b1;
    bus.req_op    = 4'd4;
    bus.req_a     = 32'd3;
    bus.req_b     = 32'd4;
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("clr mul issued", 64'(alu_op), 64'd4);
    @(negedge clock);
    clear = 1'b1;
    #1;
    chk("clr req_ready", 64'(bus.req_ready), 64'd1);
    chk("clr alu_op", 64'(alu_op), 64'd0);
    chk("clr rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("clr rsp_lo", 64'(bus.rsp_lo), 64'd0);
    @(negedge clock);
    clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("clr no response", 64'(bus.rsp_valid), 64'd0);
      chk("clr stays idle", 64'(bus.req_ready), 64'd1);
    end

    // Normal operation resumes after clear
    run_txn(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
